// File: rtl/mvm_stream_loader.sv
// Stream front/back end for the 8x8 matrix-vector core.
// Takes A (row-major) then b as a byte stream and transposes A into column
// writes for the row FIFOs. It pushes b, waits for a fresh done edge from the
// core, and then returns the DIM results as a valid/ready stream.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// CLEAR     | one cycle; the accumulator-clear pulse is issued from here
// LOAD_A    | accept DIM*DIM bytes of A into the local buffer
// PUSH_A    | write one column per cycle to all row FIFOs (DIM cycles)
// LOAD_B    | accept DIM bytes of b, each forwarded to the vector FIFO
// WAIT_DONE | wait for a 0->1 edge on mvm_done (a level already high is stale)
// SETTLE    | down-count the MAC drain, then latch every mvm_out lane
// DRAIN     | present the results on r_*, element 0 first
module mvm_stream_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int DIM        = 8,
  parameter int SETTLE     = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [DATA_WIDTH-1:0]                s_data,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  output logic                                 clr,
  output logic                                 a_wren,
  output logic [DIM-1:0][DATA_WIDTH-1:0]       a_fifo_in,
  output logic                                 b_wren,
  output logic [DATA_WIDTH-1:0]                b_fifo_in,
  input  logic                                 mvm_done,
  input  logic [DIM-1:0][3*DATA_WIDTH-1:0]     mvm_out,
  output logic [3*DATA_WIDTH-1:0]              r_data,
  output logic                                 r_valid,
  input  logic                                 r_ready,
  output logic                                 r_last,
  output logic                                 busy
);

  localparam int RW = 3 * DATA_WIDTH;
  localparam int CW = $clog2(DIM);
  localparam int BW = $clog2(DIM * DIM);
  localparam int SW = $clog2(SETTLE + 1);

  localparam logic [BW-1:0] BYTE_LAST = BW'(DIM * DIM - 1);
  localparam logic [CW-1:0] IDX_LAST  = CW'(DIM - 1);
  localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE);

  typedef enum logic [2:0] {
    S_CLEAR, S_LOAD_A, S_PUSH_A, S_LOAD_B, S_WAIT_DONE, S_SETTLE, S_DRAIN
  } state_t;

  state_t state, state_nxt;

  logic [DIM-1:0][DIM-1:0][DATA_WIDTH-1:0] abuf;
  logic [DIM-1:0][RW-1:0]                  res;
  logic [BW-1:0]                           byte_cnt;
  // Shared index: column in PUSH_A, element in LOAD_B and DRAIN.
  logic [CW-1:0]                           idx;
  logic [SW-1:0]                           settle_cnt;
  logic                                    done_q;

  logic s_fire, r_fire, done_rise;

  assign s_fire    = s_valid && s_ready;
  assign r_fire    = r_valid && r_ready;
  assign done_rise = mvm_done && !done_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_CLEAR;
    else        state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_CLEAR:     state_nxt = S_LOAD_A;
      S_LOAD_A:    if (s_fire && byte_cnt == BYTE_LAST) state_nxt = S_PUSH_A;
      S_PUSH_A:    if (idx == IDX_LAST) state_nxt = S_LOAD_B;
      S_LOAD_B:    if (s_fire && idx == IDX_LAST) state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: if (done_rise) state_nxt = S_SETTLE;
      S_SETTLE:    if (settle_cnt == '0) state_nxt = S_DRAIN;
      S_DRAIN:     if (r_fire && idx == IDX_LAST) state_nxt = S_CLEAR;
      default:     state_nxt = S_CLEAR;
    endcase
  end

  // Registered outputs, buffers and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ready    <= 1'b0;
      clr        <= 1'b0;
      a_wren     <= 1'b0;
      a_fifo_in  <= '0;
      b_wren     <= 1'b0;
      b_fifo_in  <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      busy       <= 1'b0;
      abuf       <= '0;
      res        <= '0;
      byte_cnt   <= '0;
      idx        <= '0;
      settle_cnt <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q  <= mvm_done;
      clr     <= (state == S_CLEAR);
      busy    <= (state_nxt != S_CLEAR);
      // s_ready tracks the load states, so it falls with the final byte.
      s_ready <= (state_nxt == S_LOAD_A) || (state_nxt == S_LOAD_B);

      if (state == S_LOAD_A && s_fire) begin
        abuf[byte_cnt[BW-1:CW]][byte_cnt[CW-1:0]] <= s_data;
        byte_cnt <= (byte_cnt == BYTE_LAST) ? '0 : byte_cnt + BW'(1);
      end

      a_wren <= (state == S_PUSH_A);
      if (state == S_PUSH_A) begin
        for (int i = 0; i < DIM; i++) a_fifo_in[i] <= abuf[i][idx];
      end

      b_wren <= (state == S_LOAD_B) && s_fire;
      if (state == S_LOAD_B && s_fire) b_fifo_in <= s_data;

      if (state != state_nxt) begin
        idx <= '0;
      end else if ((state == S_PUSH_A) || (state == S_LOAD_B && s_fire) ||
                   (state == S_DRAIN && r_fire)) begin
        idx <= idx + CW'(1);
      end

      if (state == S_WAIT_DONE && done_rise) begin
        settle_cnt <= SETTLE_LD;
      end else if (state == S_SETTLE && settle_cnt != '0) begin
        settle_cnt <= settle_cnt - SW'(1);
      end

      // All lanes are captured together so a later change on mvm_out can't tear the set.
      if (state == S_SETTLE && settle_cnt == '0) begin
        res     <= mvm_out;
        r_valid <= 1'b1;
        r_data  <= mvm_out[0];
        r_last  <= (DIM == 1);
      end

      if (state == S_DRAIN && r_fire) begin
        if (idx == IDX_LAST) begin
          r_valid <= 1'b0;
          r_last  <= 1'b0;
        end else begin
          r_data <= res[idx + CW'(1)];
          r_last <= ((idx + CW'(1)) == IDX_LAST);
        end
      end
    end
  end

endmodule
